// File: rtl/pipe_stage_buf_pkg.sv
// Shared types for the pipeline stage buffer: handshake state encoding and the
// per-stage packed payload structs with their bubble (squashed-entry) values.
package pipe_stage_buf_pkg;

    // Encoding doubles as the occupancy count (0, 1 or 2 entries held).
    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pstage_state_t;

    // addi x0, x0, 0: the canonical NOP loaded into squashed fetch slots.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        reg_w;
        logic        mem_r;
        logic        mem_w;
    } idex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        reg_w;
        logic        mem_r;
        logic        mem_w;
    } exmem_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_w;
    } memwb_t;

    // Bubbles carry no side effects: NOP in fetch, all write/memory enables low.
    localparam ifid_t  IFID_BUBBLE  = '{pc: 32'h0, instr: NOP_INSTR};
    localparam idex_t  IDEX_BUBBLE  = '0;
    localparam exmem_t EXMEM_BUBBLE = '0;
    localparam memwb_t MEMWB_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready handshake bundle for one pipeline stage: the upstream (in_*) and
// downstream (out_*) sides. master = the environment around the stage, slave = the stage.
interface pipe_stage_buf_if #(
    parameter int W = 32
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_buf_sat_cnt.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module pipe_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // Count qualifying cycles, sticking at all-ones instead of wrapping.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic pipeline stage register with valid/ready handshake, optional 2-entry
// skid buffer, synchronous flush with bubble insertion and a stall-cycle counter.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int           W          = 32,
    parameter int           SKID_EN    = 1,
    parameter logic [W-1:0] BUBBLE_VAL = '0,
    parameter logic [W-1:0] KEEP_MASK  = '0,
    parameter int           CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             clr_stats,
    pipe_stage_buf_if.slave  bus,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    pstage_state_t state, state_nxt;
    logic [W-1:0]  main_q, main_nxt;
    logic [W-1:0]  skid_q, skid_nxt;
    logic          out_valid_q;
    logic          in_ready;
    logic          accept;
    logic          drain;

    assign accept = bus.in_valid & in_ready;
    assign drain  = out_valid_q & bus.out_ready;

    // Next state and entry contents; flush overrides any accept/drain this cycle.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            state_nxt = PS_EMPTY;
            main_nxt  = (bus.in_data & KEEP_MASK) | (BUBBLE_VAL & ~KEEP_MASK);
            skid_nxt  = BUBBLE_VAL;
        end else begin
            case (state)
                PS_EMPTY: begin
                    if (accept) begin
                        state_nxt = PS_ONE;
                        main_nxt  = bus.in_data;
                    end
                end
                PS_ONE: begin
                    if (accept && drain) begin
                        main_nxt = bus.in_data;
                    end else if (accept && (SKID_EN != 0)) begin
                        state_nxt = PS_TWO;
                        skid_nxt  = bus.in_data;
                    end else if (drain) begin
                        state_nxt = PS_EMPTY;
                        main_nxt  = BUBBLE_VAL;
                    end
                end
                PS_TWO: begin
                    if (drain) begin
                        state_nxt = PS_ONE;
                        main_nxt  = skid_q;
                        skid_nxt  = BUBBLE_VAL;
                    end
                end
                default: begin
                    state_nxt = PS_EMPTY;
                    main_nxt  = BUBBLE_VAL;
                    skid_nxt  = BUBBLE_VAL;
                end
            endcase
        end
    end

    // State, payload registers and registered out_valid.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= PS_EMPTY;
            main_q      <= BUBBLE_VAL;
            skid_q      <= BUBBLE_VAL;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            main_q      <= main_nxt;
            skid_q      <= skid_nxt;
            out_valid_q <= (state_nxt != PS_EMPTY);
        end
    end

    generate
        if (SKID_EN != 0) begin : gen_skid
            logic in_ready_q;

            // Registered in_ready: the skid entry absorbs the one-cycle late stall.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_nxt != PS_TWO);
                end
            end

            assign in_ready = in_ready_q;
        end else begin : gen_single
            // Without a skid entry, space frees up in the same cycle the entry drains.
            assign in_ready = ~out_valid_q | bus.out_ready;
        end
    endgenerate

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign occupancy     = 2'(state);

    pipe_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (out_valid_q & ~bus.out_ready),
        .clr  (clr_stats),
        .cnt  (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: a vector table on a skid instance,
// hand-written saturation/reset sequences, and a random stream against a
// one-entry model for the non-skid variant.
module tb_pipe_stage_buf;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // DUT A: skid, KEEP_MASK=0x3F, BUBBLE_VAL=0
    pipe_stage_buf_if #(.W(32)) if_a ();
    logic        a_flush, a_clr;
    logic [1:0]  a_occ;
    logic [15:0] a_stall;
    pipe_stage_buf #(.W(32), .SKID_EN(1), .BUBBLE_VAL(32'h0), .KEEP_MASK(32'h3F), .CNT_W(16)) dut_a (
        .CLK(CLK), .nRST(nRST), .flush(a_flush), .clr_stats(a_clr),
        .bus(if_a), .occupancy(a_occ), .stall_cnt(a_stall)
    );

    // DUT B: skid, CNT_W=3, NOP bubble
    pipe_stage_buf_if #(.W(32)) if_b ();
    logic        b_flush, b_clr;
    logic [1:0]  b_occ;
    logic [2:0]  b_stall;
    pipe_stage_buf #(.W(32), .SKID_EN(1), .BUBBLE_VAL(32'h13), .KEEP_MASK(32'h0), .CNT_W(3)) dut_b (
        .CLK(CLK), .nRST(nRST), .flush(b_flush), .clr_stats(b_clr),
        .bus(if_b), .occupancy(b_occ), .stall_cnt(b_stall)
    );

    // DUT C: single register, combinational in_ready
    pipe_stage_buf_if #(.W(32)) if_c ();
    logic        c_flush, c_clr;
    logic [1:0]  c_occ;
    logic [15:0] c_stall;
    pipe_stage_buf #(.W(32), .SKID_EN(0), .BUBBLE_VAL(32'h0), .KEEP_MASK(32'h0), .CNT_W(16)) dut_c (
        .CLK(CLK), .nRST(nRST), .flush(c_flush), .clr_stats(c_clr),
        .bus(if_c), .occupancy(c_occ), .stall_cnt(c_stall)
    );

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        ov;
        logic [31:0] od;
        logic        ir;
        logic [1:0]  occ;
        logic [15:0] st;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic vec_t mkv(input logic fl, input logic iv, input logic [31:0] id, input logic ordy,
                                 input logic ov, input logic [31:0] od, input logic ir,
                                 input logic [1:0] occ, input logic [15:0] st);
        vec_t v;
        v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
        v.ov = ov; v.od = od; v.ir = ir; v.occ = occ; v.st = st;
        return v;
    endfunction

    task automatic idle_all();
        a_flush = 0; a_clr = 0; if_a.in_valid = 0; if_a.in_data = '0; if_a.out_ready = 0;
        b_flush = 0; b_clr = 0; if_b.in_valid = 0; if_b.in_data = '0; if_b.out_ready = 0;
        c_flush = 0; c_clr = 0; if_c.in_valid = 0; if_c.in_data = '0; if_c.out_ready = 0;
    endtask

    logic        mv, iv, ordy, exp_ir, acc, drn;
    logic [31:0] md, seq;
    int unsigned stall_m;

    initial begin
        //         fl iv in_data        ordy  ov out_data      ir occ stall
        // stream A..D, one per cycle
        vecs[0]  = mkv(0, 1, 32'hA000_000A, 1,  1, 32'hA000_000A, 1, 1, 0);
        vecs[1]  = mkv(0, 1, 32'hB000_000B, 1,  1, 32'hB000_000B, 1, 1, 0);
        vecs[2]  = mkv(0, 1, 32'hC000_000C, 1,  1, 32'hC000_000C, 1, 1, 0);
        vecs[3]  = mkv(0, 1, 32'hD000_000D, 1,  1, 32'hD000_000D, 1, 1, 0);
        vecs[4]  = mkv(0, 0, 32'h0,         1,  0, 32'h0,         1, 0, 0);
        // backpressure into skid, then release A then B (in_valid ignored while full)
        vecs[5]  = mkv(0, 1, 32'h0000_1111, 0,  1, 32'h0000_1111, 1, 1, 0);
        vecs[6]  = mkv(0, 1, 32'h0000_2222, 0,  1, 32'h0000_1111, 0, 2, 1);
        vecs[7]  = mkv(0, 0, 32'h0,         0,  1, 32'h0000_1111, 0, 2, 2);
        vecs[8]  = mkv(0, 1, 32'h0000_DEAD, 1,  1, 32'h0000_2222, 1, 1, 2);
        vecs[9]  = mkv(0, 0, 32'h0,         1,  0, 32'h0,         1, 0, 2);
        // fill to two, flush with input valid: kept bits only, input dropped
        vecs[10] = mkv(0, 1, 32'h5555_0001, 0,  1, 32'h5555_0001, 1, 1, 2);
        vecs[11] = mkv(0, 1, 32'h5555_0002, 0,  1, 32'h5555_0001, 0, 2, 3);
        vecs[12] = mkv(1, 1, 32'hFFFF_FFFF, 0,  0, 32'h0000_003F, 1, 0, 4);
        vecs[13] = mkv(0, 0, 32'h0,         1,  0, 32'h0000_003F, 1, 0, 4);
        // flush in a drain cycle, then the stage restarts cleanly
        vecs[14] = mkv(0, 1, 32'h0000_7777, 1,  1, 32'h0000_7777, 1, 1, 4);
        vecs[15] = mkv(1, 0, 32'h0000_0100, 1,  0, 32'h0,         1, 0, 4);
        vecs[16] = mkv(0, 1, 32'h1234_5678, 1,  1, 32'h1234_5678, 1, 1, 4);
        vecs[17] = mkv(0, 0, 32'h0,         1,  0, 32'h0,         1, 0, 4);

        idle_all();
        nRST = 0;
        repeat (2) @(negedge CLK);
        nRST = 1;

        // reset state
        #1;
        check("rst a out_valid", 32'(if_a.out_valid), 32'd0);
        check("rst a in_ready",  32'(if_a.in_ready),  32'd1);
        check("rst a occupancy", 32'(a_occ),          32'd0);
        check("rst a stall_cnt", 32'(a_stall),        32'd0);
        check("rst b out_data",  if_b.out_data,       32'h13);

        // vector table on DUT A
        for (int i = 0; i < NV; i++) begin
            @(negedge CLK);
            a_flush = vecs[i].fl; if_a.in_valid = vecs[i].iv;
            if_a.in_data = vecs[i].id; if_a.out_ready = vecs[i].ordy;
            @(posedge CLK);
            #1;
            check($sformatf("v%0d out_valid", i), 32'(if_a.out_valid), 32'(vecs[i].ov));
            check($sformatf("v%0d out_data",  i), if_a.out_data,       vecs[i].od);
            check($sformatf("v%0d in_ready",  i), 32'(if_a.in_ready),  32'(vecs[i].ir));
            check($sformatf("v%0d occupancy", i), 32'(a_occ),          32'(vecs[i].occ));
            check($sformatf("v%0d stall_cnt", i), 32'(a_stall),        32'(vecs[i].st));
        end
        @(negedge CLK);
        idle_all();

        // saturation at CNT_W=3: 10 cycles stalled with valid held
        @(negedge CLK);
        if_b.in_valid = 1; if_b.in_data = 32'h0000_00B0; if_b.out_ready = 0;
        repeat (10) @(posedge CLK);
        #1;
        check("sat stall_cnt", 32'(b_stall),        32'd7);
        check("sat occupancy", 32'(b_occ),          32'd2);
        check("sat in_ready",  32'(if_b.in_ready),  32'd0);
        check("sat out_data",  if_b.out_data,       32'hB0);
        @(negedge CLK);
        if_b.in_valid = 0; b_clr = 1;
        @(posedge CLK);
        #1;
        check("clr wins over inc", 32'(b_stall), 32'd0);
        @(negedge CLK);
        b_clr = 0;
        @(posedge CLK);
        #1;
        check("count after clr", 32'(b_stall), 32'd1);

        // async reset while two entries held
        @(negedge CLK);
        check("pre-reset occupancy", 32'(b_occ), 32'd2);
        nRST = 0;
        #1;
        check("async rst out_valid", 32'(if_b.out_valid), 32'd0);
        check("async rst out_data",  if_b.out_data,       32'h13);
        check("async rst stall_cnt", 32'(b_stall),        32'd0);
        check("async rst occupancy", 32'(b_occ),          32'd0);
        check("async rst in_ready",  32'(if_b.in_ready),  32'd1);
        idle_all();
        @(negedge CLK);
        nRST = 1;

        // non-skid variant: random handshakes against a one-entry model
        mv = 0; md = '0; seq = 32'h100; stall_m = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge CLK);
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            if_c.in_valid = iv; if_c.in_data = seq; if_c.out_ready = ordy;
            #1;
            exp_ir = ~mv | ordy;
            check("c in_ready",  32'(if_c.in_ready),  32'(exp_ir));
            check("c out_valid", 32'(if_c.out_valid), 32'(mv));
            check("c out_data",  if_c.out_data,       mv ? md : 32'h0);
            check("c occupancy", 32'(c_occ),          32'(mv));
            if (mv && !ordy) stall_m++;
            drn = mv & ordy;
            acc = iv & exp_ir;
            if (acc) begin
                mv = 1; md = seq; seq = seq + 1;
            end else if (drn) begin
                mv = 0;
            end
        end
        @(negedge CLK);
        idle_all();
        #1;
        check("c stall_cnt", 32'(c_stall), stall_m);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
